// File: rtl/calc_port_sequencer_if.sv
// Bundle between the calc_port_sequencer, its transaction source and the calc2 DUT pins.
// master = bench/DUT side, slave = sequencer side.
interface calc_port_sequencer_if #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 32,
    parameter int CMD_W  = 4,
    parameter int TAG_W  = 2
);
    logic [NPORTS-1:0]          enq_valid;
    logic [NPORTS-1:0]          enq_ready;
    logic [NPORTS*CMD_W-1:0]    enq_cmd;
    logic [NPORTS*DATA_W-1:0]   enq_op1;
    logic [NPORTS*DATA_W-1:0]   enq_op2;
    logic [NPORTS*CMD_W-1:0]    req_cmd_out;
    logic [NPORTS*DATA_W-1:0]   req_data_out;
    logic [NPORTS*TAG_W-1:0]    req_tag_out;
    logic [NPORTS*2-1:0]        resp_in;
    logic [NPORTS*DATA_W-1:0]   resp_data_in;
    logic [NPORTS*TAG_W-1:0]    resp_tag_in;
    logic [NPORTS-1:0]          done_valid;
    logic [NPORTS*2-1:0]        done_resp;
    logic [NPORTS*DATA_W-1:0]   done_data;
    logic [NPORTS*TAG_W-1:0]    done_tag;
    logic [NPORTS*(TAG_W+1)-1:0] outstanding;
    logic [NPORTS-1:0]          timeout_err;
    logic [NPORTS-1:0]          spurious_err;

    modport master (
        output enq_valid, enq_cmd, enq_op1, enq_op2,
        output resp_in, resp_data_in, resp_tag_in,
        input  enq_ready, req_cmd_out, req_data_out, req_tag_out,
        input  done_valid, done_resp, done_data, done_tag,
        input  outstanding, timeout_err, spurious_err
    );

    modport slave (
        input  enq_valid, enq_cmd, enq_op1, enq_op2,
        input  resp_in, resp_data_in, resp_tag_in,
        output enq_ready, req_cmd_out, req_data_out, req_tag_out,
        output done_valid, done_resp, done_data, done_tag,
        output outstanding, timeout_err, spurious_err
    );
endinterface

// File: rtl/calc_port_sequencer.sv
// Per-port request FIFO + two-cycle cmd/operand issuer for calc2,
// with automatic tag allocation, completion return and error flags.
module calc_port_sequencer #(
    parameter int NPORTS  = 4,
    parameter int DATA_W  = 32,
    parameter int CMD_W   = 4,
    parameter int TAG_W   = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                  c_clk,
    input  logic                  reset,
    calc_port_sequencer_if.slave  bus
);
    localparam int NTAG = 2 ** TAG_W;
    localparam int PW   = $clog2(DEPTH);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam int EW   = CMD_W + 2 * DATA_W;
    localparam int OW   = TAG_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_OP1, S_OP2} state_e;

    state_e            state_q [NPORTS];
    logic [EW-1:0]     mem_q   [NPORTS][DEPTH];
    logic [PW-1:0]     wptr_q  [NPORTS];
    logic [PW-1:0]     rptr_q  [NPORTS];
    logic [PW:0]       cnt_q   [NPORTS];
    logic [NTAG-1:0]   busy_q  [NPORTS];
    logic [NTAG-1:0]   busy_d  [NPORTS];
    logic [TW-1:0]     tmo_q   [NPORTS];
    logic [TW-1:0]     tmo_d   [NPORTS];
    logic [DATA_W-1:0] op2_q   [NPORTS];

    logic [NPORTS*CMD_W-1:0]  req_cmd_q;
    logic [NPORTS*DATA_W-1:0] req_data_q;
    logic [NPORTS*TAG_W-1:0]  req_tag_q;
    logic [NPORTS-1:0]        done_valid_q;
    logic [NPORTS*2-1:0]      done_resp_q;
    logic [NPORTS*DATA_W-1:0] done_data_q;
    logic [NPORTS*TAG_W-1:0]  done_tag_q;
    logic [NPORTS*OW-1:0]     outst_q;
    logic [NPORTS-1:0]        tmo_err_q;
    logic [NPORTS-1:0]        spur_err_q;

    logic [NPORTS-1:0] full_w;
    logic [NPORTS-1:0] push_w;
    logic [NPORTS-1:0] issue_w;
    logic [NPORTS-1:0] hit_w;
    logic [NPORTS-1:0] spur_w;
    logic [NPORTS-1:0] fire_w;
    logic [NPORTS-1:0] has_free_w;
    logic [TAG_W-1:0]  free_w [NPORTS];
    logic [TAG_W-1:0]  rtag_w [NPORTS];
    logic [1:0]        rsp_w  [NPORTS];
    logic [EW-1:0]     head_w [NPORTS];
    logic [OW-1:0]     pcnt_w [NPORTS];

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            full_w[p]  = cnt_q[p] == (PW+1)'(DEPTH);
            push_w[p]  = bus.enq_valid[p] && !full_w[p];
            head_w[p]  = mem_q[p][rptr_q[p]];
            rsp_w[p]   = bus.resp_in[p*2 +: 2];
            rtag_w[p]  = bus.resp_tag_in[p*TAG_W +: TAG_W];
            has_free_w[p] = 1'b0;
            free_w[p]     = '0;
            // Descending scan so the lowest free tag is the last written.
            for (int t = NTAG - 1; t >= 0; t--) begin
                if (!busy_q[p][t]) begin
                    has_free_w[p] = 1'b1;
                    free_w[p]     = TAG_W'(t);
                end
            end
            issue_w[p] = (state_q[p] != S_OP1) && (cnt_q[p] != '0)
                         && has_free_w[p];
            hit_w[p]   = (rsp_w[p] != 2'b0) && busy_q[p][rtag_w[p]];
            spur_w[p]  = (rsp_w[p] != 2'b0) && !busy_q[p][rtag_w[p]];
            fire_w[p]  = 1'b0;
            tmo_d[p]   = '0;
            if ((busy_q[p] != '0) && (rsp_w[p] == 2'b0)) begin
                if (tmo_q[p] >= TW'(TIMEOUT - 1)) fire_w[p] = 1'b1;
                else tmo_d[p] = tmo_q[p] + TW'(1);
            end
            // A fresh allocation wins over a same-edge clear.
            busy_d[p] = busy_q[p];
            if (hit_w[p]) busy_d[p][rtag_w[p]] = 1'b0;
            if (fire_w[p]) busy_d[p] = '0;
            if (issue_w[p]) busy_d[p][free_w[p]] = 1'b1;
            pcnt_w[p] = '0;
            for (int t = 0; t < NTAG; t++) begin
                pcnt_w[p] = pcnt_w[p] + OW'(busy_d[p][t]);
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int p = 0; p < NPORTS; p++) begin
                state_q[p] <= S_IDLE;
                wptr_q[p]  <= '0;
                rptr_q[p]  <= '0;
                cnt_q[p]   <= '0;
                busy_q[p]  <= '0;
                tmo_q[p]   <= '0;
                op2_q[p]   <= '0;
            end
            req_cmd_q    <= '0;
            req_data_q   <= '0;
            req_tag_q    <= '0;
            done_valid_q <= '0;
            done_resp_q  <= '0;
            done_data_q  <= '0;
            done_tag_q   <= '0;
            outst_q      <= '0;
            tmo_err_q    <= '0;
            spur_err_q   <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (push_w[p]) begin
                    mem_q[p][wptr_q[p]] <= {bus.enq_cmd[p*CMD_W +: CMD_W],
                                            bus.enq_op1[p*DATA_W +: DATA_W],
                                            bus.enq_op2[p*DATA_W +: DATA_W]};
                    wptr_q[p] <= wptr_q[p] + PW'(1);
                end
                if (issue_w[p]) rptr_q[p] <= rptr_q[p] + PW'(1);
                cnt_q[p]  <= cnt_q[p] + (PW+1)'(push_w[p])
                             - (PW+1)'(issue_w[p]);
                busy_q[p] <= busy_d[p];
                tmo_q[p]  <= tmo_d[p];
                outst_q[p*OW +: OW] <= pcnt_w[p];
                done_valid_q[p] <= hit_w[p];
                if (hit_w[p]) begin
                    done_resp_q[p*2 +: 2]           <= rsp_w[p];
                    done_data_q[p*DATA_W +: DATA_W] <= bus.resp_data_in[p*DATA_W +: DATA_W];
                    done_tag_q[p*TAG_W +: TAG_W]    <= rtag_w[p];
                end
                if (spur_w[p]) spur_err_q[p] <= 1'b1;
                if (fire_w[p]) tmo_err_q[p] <= 1'b1;
                unique case (1'b1)
                    issue_w[p]: begin
                        state_q[p] <= S_OP1;
                        req_cmd_q[p*CMD_W +: CMD_W]    <= head_w[p][EW-1 -: CMD_W];
                        req_data_q[p*DATA_W +: DATA_W] <= head_w[p][2*DATA_W-1 -: DATA_W];
                        req_tag_q[p*TAG_W +: TAG_W]    <= free_w[p];
                        op2_q[p] <= head_w[p][DATA_W-1:0];
                    end
                    (state_q[p] == S_OP1): begin
                        state_q[p] <= S_OP2;
                        req_cmd_q[p*CMD_W +: CMD_W]    <= '0;
                        req_data_q[p*DATA_W +: DATA_W] <= op2_q[p];
                        req_tag_q[p*TAG_W +: TAG_W]    <= '0;
                    end
                    default: begin
                        state_q[p] <= S_IDLE;
                        req_cmd_q[p*CMD_W +: CMD_W]    <= '0;
                        req_data_q[p*DATA_W +: DATA_W] <= '0;
                        req_tag_q[p*TAG_W +: TAG_W]    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.enq_ready    = ~full_w;
    assign bus.req_cmd_out  = req_cmd_q;
    assign bus.req_data_out = req_data_q;
    assign bus.req_tag_out  = req_tag_q;
    assign bus.done_valid   = done_valid_q;
    assign bus.done_resp    = done_resp_q;
    assign bus.done_data    = done_data_q;
    assign bus.done_tag     = done_tag_q;
    assign bus.outstanding  = outst_q;
    assign bus.timeout_err  = tmo_err_q;
    assign bus.spurious_err = spur_err_q;
endmodule

// File: tb/tb_calc_port_sequencer.sv
// Bench for calc_port_sequencer: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based port model.
module tb_calc_port_sequencer;
    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int TW    = 2;
    localparam int OW    = TW + 1;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    calc_port_sequencer_if #(.NPORTS(NP), .DATA_W(DW), .CMD_W(CW), .TAG_W(TW)) bus ();

    calc_port_sequencer #(
        .NPORTS(NP), .DATA_W(DW), .CMD_W(CW), .TAG_W(TW),
        .DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .c_clk (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        int          cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } ent_t;

    // stimulus staged for the next cycle
    bit          s_rst;
    bit          s_v     [NP];
    int          s_cmd   [NP];
    logic [31:0] s_op1   [NP];
    logic [31:0] s_op2   [NP];
    int          s_resp  [NP];
    int          s_rtag  [NP];
    logic [31:0] s_rdata [NP];

    // reference model: pending work, busy tags, issue phase, idle timer
    ent_t        mq    [NP][$];
    int          mbusy [NP];
    int          mph   [NP];
    int          mcnt  [NP];
    logic [31:0] mop2  [NP];
    int          e_cmd [NP];
    int          e_tag [NP];
    logic [31:0] e_data[NP];
    int          e_dv  [NP];
    int          e_dresp[NP];
    int          e_dtag[NP];
    logic [31:0] e_ddata[NP];
    int          e_to  [NP];
    int          e_sp  [NP];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int p,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s port%0d observed=%0h expected=%0h", tag, p, obs, exp);
        end
    endtask

    function automatic int popc(input int x);
        int n = 0;
        for (int i = 0; i < 2 ** TW; i++) n += (x >> i) & 1;
        return n;
    endfunction

    function automatic int lowfree(input int b);
        for (int i = 0; i < 2 ** TW; i++) if (((b >> i) & 1) == 0) return i;
        return -1;
    endfunction

    function automatic int lowbusy(input int b);
        for (int i = 0; i < 2 ** TW; i++) if (((b >> i) & 1) == 1) return i;
        return -1;
    endfunction

    function automatic logic [63:0] o_cmd(input int p);
        return 64'(bus.req_cmd_out[p*CW +: CW]);
    endfunction
    function automatic logic [63:0] o_data(input int p);
        return 64'(bus.req_data_out[p*DW +: DW]);
    endfunction
    function automatic logic [63:0] o_tag(input int p);
        return 64'(bus.req_tag_out[p*TW +: TW]);
    endfunction
    function automatic logic [63:0] o_out(input int p);
        return 64'(bus.outstanding[p*OW +: OW]);
    endfunction

    task automatic model_step();
        for (int p = 0; p < NP; p++) begin
            if (s_rst) begin
                mq[p].delete();
                mbusy[p] = 0; mph[p] = 0; mcnt[p] = 0; mop2[p] = '0;
                e_cmd[p] = 0; e_tag[p] = 0; e_data[p] = '0;
                e_dv[p] = 0; e_dresp[p] = 0; e_dtag[p] = 0; e_ddata[p] = '0;
                e_to[p] = 0; e_sp[p] = 0;
            end else begin
                int   free;
                int   setm;
                int   nb;
                bit   push, hit, spur, fire;
                ent_t e;
                free = lowfree(mbusy[p]);
                push = s_v[p] && (mq[p].size() < DEPTH);
                hit  = (s_resp[p] != 0) && (((mbusy[p] >> s_rtag[p]) & 1) == 1);
                spur = (s_resp[p] != 0) && !hit;
                fire = 0;
                setm = 0;
                if (mph[p] == 1) begin
                    e_cmd[p] = 0; e_data[p] = mop2[p]; e_tag[p] = 0; mph[p] = 2;
                end else if (mq[p].size() > 0 && free >= 0) begin
                    e = mq[p].pop_front();
                    e_cmd[p] = e.cmd; e_data[p] = e.op1; e_tag[p] = free;
                    mop2[p] = e.op2; setm = 1 << free; mph[p] = 1;
                end else begin
                    e_cmd[p] = 0; e_data[p] = '0; e_tag[p] = 0; mph[p] = 0;
                end
                if (push) mq[p].push_back('{s_cmd[p], s_op1[p], s_op2[p]});
                if (mbusy[p] == 0 || s_resp[p] != 0) mcnt[p] = 0;
                else if (mcnt[p] + 1 >= TMO) begin fire = 1; mcnt[p] = 0; end
                else mcnt[p]++;
                e_dv[p] = hit;
                if (hit) begin
                    e_dresp[p] = s_resp[p]; e_ddata[p] = s_rdata[p]; e_dtag[p] = s_rtag[p];
                end
                if (spur) e_sp[p] = 1;
                if (fire) e_to[p] = 1;
                nb = mbusy[p];
                if (hit) nb = nb & ~(1 << s_rtag[p]);
                if (fire) nb = 0;
                mbusy[p] = nb | setm;
            end
        end
    endtask

    task automatic compare_all();
        for (int p = 0; p < NP; p++) begin
            chk("enq_ready", p, 64'(bus.enq_ready[p]), 64'(mq[p].size() < DEPTH));
            chk("req_cmd", p, o_cmd(p), 64'(e_cmd[p]));
            chk("req_data", p, o_data(p), 64'(e_data[p]));
            chk("req_tag", p, o_tag(p), 64'(e_tag[p]));
            chk("done_valid", p, 64'(bus.done_valid[p]), 64'(e_dv[p]));
            chk("done_resp", p, 64'(bus.done_resp[p*2 +: 2]), 64'(e_dresp[p]));
            chk("done_data", p, 64'(bus.done_data[p*DW +: DW]), 64'(e_ddata[p]));
            chk("done_tag", p, 64'(bus.done_tag[p*TW +: TW]), 64'(e_dtag[p]));
            chk("outstanding", p, o_out(p), 64'(popc(mbusy[p])));
            chk("timeout_err", p, 64'(bus.timeout_err[p]), 64'(e_to[p]));
            chk("spurious_err", p, 64'(bus.spurious_err[p]), 64'(e_sp[p]));
        end
    endtask

    task automatic cyc();
        rst = s_rst;
        for (int p = 0; p < NP; p++) begin
            bus.enq_valid[p]               = s_v[p];
            bus.enq_cmd[p*CW +: CW]        = CW'(s_cmd[p]);
            bus.enq_op1[p*DW +: DW]        = s_op1[p];
            bus.enq_op2[p*DW +: DW]        = s_op2[p];
            bus.resp_in[p*2 +: 2]          = 2'(s_resp[p]);
            bus.resp_tag_in[p*TW +: TW]    = TW'(s_rtag[p]);
            bus.resp_data_in[p*DW +: DW]   = s_rdata[p];
        end
        model_step();
        s_rst = 0;
        for (int p = 0; p < NP; p++) begin
            s_v[p] = 0; s_resp[p] = 0;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic push(input int p, input int cmd, input int op1, input int op2);
        s_v[p] = 1; s_cmd[p] = cmd; s_op1[p] = 32'(op1); s_op2[p] = 32'(op2);
    endtask

    task automatic resp(input int p, input int r, input int tag, input int data);
        s_resp[p] = r; s_rtag[p] = tag; s_rdata[p] = 32'(data);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            bit idle;
            idle = 1;
            for (int p = 0; p < NP; p++)
                if (mq[p].size() != 0 || mbusy[p] != 0 || mph[p] != 0) idle = 0;
            if (idle) break;
            for (int p = 0; p < NP; p++)
                if (mbusy[p] != 0) resp(p, 1, lowbusy(mbusy[p]), int'($urandom));
            cyc();
        end
        for (int p = 0; p < NP; p++) chk("drained", p, o_out(p), 64'd0);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            s_v[p] = 0; s_cmd[p] = 0; s_op1[p] = '0; s_op2[p] = '0;
            s_resp[p] = 0; s_rtag[p] = 0; s_rdata[p] = '0;
        end

        // reset
        s_rst = 1;
        cyc();
        chk("rst_ready", 0, 64'(bus.enq_ready), 64'hF);
        chk("rst_outst", 0, 64'(bus.outstanding), 64'h0);

        // single add on port 0
        push(0, 1, 5, 7);
        cyc();
        cyc();
        chk("t1_op1_cmd", 0, o_cmd(0), 64'd1);
        chk("t1_op1_data", 0, o_data(0), 64'd5);
        chk("t1_op1_tag", 0, o_tag(0), 64'd0);
        cyc();
        chk("t1_op2_cmd", 0, o_cmd(0), 64'd0);
        chk("t1_op2_data", 0, o_data(0), 64'd7);
        resp(0, 1, 0, 12);
        cyc();
        chk("t1_done_v", 0, 64'(bus.done_valid[0]), 64'd1);
        chk("t1_done_d", 0, 64'(bus.done_data[DW-1:0]), 64'd12);
        chk("t1_outst", 0, o_out(0), 64'd0);

        // five requests on port 2, DUT silent
        for (int i = 0; i < 5; i++) begin
            push(2, i + 2, 100 + i, 200 + i);
            cyc();
        end
        repeat (5) cyc();
        chk("t2_outst4", 2, o_out(2), 64'd4);
        chk("t2_wait", 2, o_cmd(2), 64'd0);
        resp(2, 1, 1, 77);
        cyc();
        cyc();
        chk("t2_reissue_tag", 2, o_tag(2), 64'd1);
        chk("t2_reissue_data", 2, o_data(2), 64'd104);
        for (int i = 0; i < 4; i++) begin
            push(2, 9, 300 + i, 400 + i);
            cyc();
        end
        chk("t2_full", 2, 64'(bus.enq_ready[2]), 64'd0);
        push(2, 9, 999, 999);
        cyc();
        chk("t2_still_full", 2, 64'(bus.enq_ready[2]), 64'd0);
        drain();

        // all ports at once, reverse-order responses
        for (int p = 0; p < NP; p++) push(p, 3, p * 10 + 1, p + 1);
        cyc();
        cyc();
        for (int p = 0; p < NP; p++) begin
            chk("t3_cmd", p, o_cmd(p), 64'd3);
            chk("t3_tag", p, o_tag(p), 64'd0);
            chk("t3_data", p, o_data(p), 64'(p * 10 + 1));
        end
        cyc();
        for (int k = NP - 1; k >= 0; k--) begin
            resp(k, 2, 0, 1000 + k);
            cyc();
            chk("t3_done_v", k, 64'(bus.done_valid[k]), 64'd1);
            chk("t3_done_d", k, 64'(bus.done_data[k*DW +: DW]), 64'(1000 + k));
        end
        drain();

        // spurious response
        resp(1, 1, 3, 5);
        cyc();
        chk("t4_spur", 1, 64'(bus.spurious_err[1]), 64'd1);
        chk("t4_no_done", 1, 64'(bus.done_valid[1]), 64'd0);

        // timeout on port 3
        push(3, 5, 9, 1);
        cyc();
        repeat (15) cyc();
        chk("t5_not_yet", 3, 64'(bus.timeout_err[3]), 64'd0);
        chk("t5_busy", 3, o_out(3), 64'd1);
        cyc();
        chk("t5_timeout", 3, 64'(bus.timeout_err[3]), 64'd1);
        chk("t5_cleared", 3, o_out(3), 64'd0);
        push(3, 7, 11, 12);
        cyc();
        cyc();
        chk("t5_new_cmd", 3, o_cmd(3), 64'd7);
        chk("t5_new_tag", 3, o_tag(3), 64'd0);
        drain();

        // reset while in OP2 with three queued
        for (int i = 0; i < 5; i++) begin
            push(0, 4, 50 + i, 60 + i);
            cyc();
        end
        s_rst = 1;
        cyc();
        chk("t6_ready", 0, 64'(bus.enq_ready), 64'hF);
        chk("t6_outst", 0, 64'(bus.outstanding), 64'h0);
        chk("t6_terr", 0, 64'(bus.timeout_err), 64'h0);
        chk("t6_serr", 0, 64'(bus.spurious_err), 64'h0);
        repeat (3) cyc();
        for (int p = 0; p < NP; p++) chk("t6_no_issue", p, o_cmd(p), 64'd0);

        // random traffic
        repeat (600) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 99) < 30)
                    push(p, int'($urandom_range(1, 15)), int'($urandom), int'($urandom));
                if (mbusy[p] != 0 && $urandom_range(0, 99) < 35) begin
                    int tags[$];
                    for (int t = 0; t < 2 ** TW; t++)
                        if (((mbusy[p] >> t) & 1) == 1) tags.push_back(t);
                    resp(p, int'($urandom_range(1, 3)),
                         tags[$urandom_range(0, tags.size() - 1)], int'($urandom));
                end else if ($urandom_range(0, 199) == 0) begin
                    resp(p, 1, int'($urandom_range(0, 3)), int'($urandom));
                end
            end
            cyc();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
